// File: rtl/pll_dyn_cfg_ctrl.sv
// pll_dyn_cfg_ctrl: sequences the rPLL dynamic divider codes and RESET pin.
// Boots with default codes, applies runtime divider changes by resetting the
// PLL, waits for LOCK, qualifies it as stable and retries on failure.
// Everything runs on the crystal clock so it keeps working while the PLL is down.
//
// Request handshake: the requester raises cfg_req with the codes on
// cfg_idsel/cfg_fbdsel/cfg_odsel and holds both until it sees cfg_ack. The
// block raises cfg_ack (combinational, one cycle) only in LOCKED or FAILED;
// the codes are captured on the clock edge that ends the ack cycle. A request
// seen in any busy state is left pending without an ack.
module pll_dyn_cfg_ctrl #(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 65535,
    parameter int unsigned STABLE_CYCLES = 256,
    parameter int unsigned MAX_RETRY     = 3,
    parameter logic [5:0]  DEF_IDSEL     = 6'd0,
    parameter logic [5:0]  DEF_FBDSEL    = 6'd0,
    parameter logic [5:0]  DEF_ODSEL     = 6'd0
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       cfg_req,
    input  logic [5:0] cfg_idsel,
    input  logic [5:0] cfg_fbdsel,
    input  logic [5:0] cfg_odsel,
    output logic       cfg_ack,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic [5:0] pll_idsel,
    output logic [5:0] pll_fbdsel,
    output logic [5:0] pll_odsel,
    output logic       clk_ok,
    output logic       cfg_done,
    output logic       cfg_err,
    output logic       busy,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        S_RESET_PLL = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_LOCKED    = 3'd3,
        S_FAILED    = 3'd4
    } state_e;

    // One shared phase counter, wide enough for the longest phase.
    localparam int unsigned MAX_AB  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int unsigned CNT_MAX = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned RTY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RTY_W-1:0] retry_q, retry_d;
    logic [5:0]       idsel_q, idsel_d;
    logic [5:0]       fbdsel_q, fbdsel_d;
    logic [5:0]       odsel_q, odsel_d;
    logic             lock_s1_q, lock_s2_q;
    logic             done_q;
    logic             accept;
    logic             fail;
    logic             lock_s;

    assign lock_s = lock_s2_q;

    // Two-flop synchroniser for the asynchronous LOCK pin.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            lock_s1_q <= 1'b0;
            lock_s2_q <= 1'b0;
        end else begin
            lock_s1_q <= pll_lock;
            lock_s2_q <= lock_s1_q;
        end
    end

    // Next-state logic: phase counting, retry bookkeeping and request accept.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        retry_d  = retry_q;
        idsel_d  = idsel_q;
        fbdsel_d = fbdsel_q;
        odsel_d  = odsel_q;
        accept   = 1'b0;
        fail     = 1'b0;
        case (state_q)
            S_RESET_PLL: begin
                if (cnt_q >= RST_LAST) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT_LOCK: begin
                // The cycle that sees lock_s high counts as the first stable cycle.
                if (lock_s) begin
                    if (STABLE_CYCLES <= 1) begin
                        state_d = S_LOCKED;
                    end else begin
                        state_d = S_STABLE;
                        cnt_d   = CNT_W'(1);
                    end
                end else if (cnt_q >= TO_LAST) begin
                    fail = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STABLE: begin
                if (!lock_s) begin
                    fail = 1'b1;
                end else if (cnt_q >= STB_LAST) begin
                    state_d = S_LOCKED;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_LOCKED: begin
                retry_d = '0;
                // A pending request takes priority over a simultaneous lock loss.
                if (cfg_req) begin
                    accept = 1'b1;
                end else if (!lock_s) begin
                    state_d = S_RESET_PLL;
                    cnt_d   = '0;
                end
            end
            S_FAILED: begin
                if (cfg_req) begin
                    accept = 1'b1;
                end
            end
            default: begin
                state_d = S_RESET_PLL;
                cnt_d   = '0;
            end
        endcase

        if (fail) begin
            cnt_d = '0;
            if (retry_q < RTY_MAX) begin
                retry_d = retry_q + 1'b1;
                state_d = S_RESET_PLL;
            end else begin
                state_d = S_FAILED;
            end
        end

        // New codes land together with pll_reset rising, so the PLL never
        // sees a divider change while it is running.
        if (accept) begin
            state_d  = S_RESET_PLL;
            cnt_d    = '0;
            retry_d  = '0;
            idsel_d  = cfg_idsel;
            fbdsel_d = cfg_fbdsel;
            odsel_d  = cfg_odsel;
        end
    end

    // State, counters, divider codes and the LOCKED-entry pulse.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q  <= S_RESET_PLL;
            cnt_q    <= '0;
            retry_q  <= '0;
            idsel_q  <= DEF_IDSEL;
            fbdsel_q <= DEF_FBDSEL;
            odsel_q  <= DEF_ODSEL;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            retry_q  <= retry_d;
            idsel_q  <= idsel_d;
            fbdsel_q <= fbdsel_d;
            odsel_q  <= odsel_d;
            done_q   <= (state_d == S_LOCKED) && (state_q != S_LOCKED);
        end
    end

    assign cfg_ack    = accept;
    assign pll_reset  = (state_q == S_RESET_PLL) || (state_q == S_FAILED);
    assign pll_idsel  = idsel_q;
    assign pll_fbdsel = fbdsel_q;
    assign pll_odsel  = odsel_q;
    assign clk_ok     = (state_q == S_LOCKED);
    assign cfg_done   = done_q;
    assign cfg_err    = (state_q == S_FAILED);
    assign busy       = (state_q == S_RESET_PLL) || (state_q == S_WAIT_LOCK) ||
                        (state_q == S_STABLE);
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_pll_dyn_cfg_ctrl.sv
// tb_pll_dyn_cfg_ctrl: directed bench for the PLL divider sequencer with a
// behavioural LOCK model and a scoreboard for cfg_done / cfg_ack events.
module tb_pll_dyn_cfg_ctrl;

  localparam int RST_CYCLES    = 4;
  localparam int LOCK_TIMEOUT  = 20;
  localparam int STABLE_CYCLES = 8;
  localparam int MAX_RETRY     = 2;
  localparam int LOCK_DLY      = 10;
  localparam logic [5:0]  DEF_ID    = 6'd1;
  localparam logic [5:0]  DEF_FB    = 6'd2;
  localparam logic [5:0]  DEF_OD    = 6'd4;
  localparam logic [17:0] DEF_CODES = {DEF_ID, DEF_FB, DEF_OD};

  logic       sys_clk;
  logic       sys_rst_n;
  logic       cfg_req;
  logic [5:0] cfg_idsel, cfg_fbdsel, cfg_odsel;
  logic       cfg_ack;
  logic       pll_lock;
  logic       pll_reset;
  logic [5:0] pll_idsel, pll_fbdsel, pll_odsel;
  logic       clk_ok, cfg_done, cfg_err, busy;
  logic [2:0] dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int lk_cnt = 0;
  int lock_rise_cyc = 0;
  int drop_cyc = 0;
  logic lock_en;
  logic drop_pulse;

  logic [17:0] done_exp_q[$];
  logic [17:0] ack_exp_q[$];

  pll_dyn_cfg_ctrl #(
    .RST_CYCLES(RST_CYCLES), .LOCK_TIMEOUT(LOCK_TIMEOUT),
    .STABLE_CYCLES(STABLE_CYCLES), .MAX_RETRY(MAX_RETRY),
    .DEF_IDSEL(DEF_ID), .DEF_FBDSEL(DEF_FB), .DEF_ODSEL(DEF_OD)
  ) u_dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .cfg_req(cfg_req), .cfg_idsel(cfg_idsel), .cfg_fbdsel(cfg_fbdsel),
    .cfg_odsel(cfg_odsel), .cfg_ack(cfg_ack),
    .pll_lock(pll_lock), .pll_reset(pll_reset),
    .pll_idsel(pll_idsel), .pll_fbdsel(pll_fbdsel), .pll_odsel(pll_odsel),
    .clk_ok(clk_ok), .cfg_done(cfg_done), .cfg_err(cfg_err), .busy(busy),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  always @(posedge sys_clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  function automatic logic [17:0] codes();
    return {pll_idsel, pll_fbdsel, pll_odsel};
  endfunction

  function automatic logic sig(input int s);
    case (s)
      0:       return clk_ok;
      1:       return pll_reset;
      2:       return cfg_ack;
      default: return cfg_err;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Waits at negedges until signal s reaches lvl; a timeout is a failed check.
  task automatic wait_sig(input int s, input logic lvl, input string name);
    int n;
    n = 0;
    do begin
      @(negedge sys_clk);
      n++;
    end while (sig(s) !== lvl && n < 500);
    if (sig(s) !== lvl) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: timeout waiting for level %0b, got %0b", name, lvl, sig(s));
    end
  endtask

  task automatic count_reset_high(output int n);
    n = 0;
    while (n < 200) begin
      @(negedge sys_clk);
      if (pll_reset !== 1'b1) break;
      n++;
    end
  endtask

  task automatic drive_req(input logic [5:0] id, input logic [5:0] fb, input logic [5:0] od);
    @(posedge sys_clk);
    #1;
    cfg_req    = 1'b1;
    cfg_idsel  = id;
    cfg_fbdsel = fb;
    cfg_odsel  = od;
  endtask

  task automatic release_req();
    @(posedge sys_clk);
    #1;
    cfg_req = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_pll_reset"}, pll_reset, 1);
    check({tag, "_busy"},      busy, 1);
    check({tag, "_clk_ok"},    clk_ok, 0);
    check({tag, "_cfg_ack"},   cfg_ack, 0);
    check({tag, "_cfg_done"},  cfg_done, 0);
    check({tag, "_cfg_err"},   cfg_err, 0);
    check({tag, "_codes"},     codes(), DEF_CODES);
  endtask

  // ---------------- PLL LOCK model ----------------
  // LOCK rises LOCK_DLY cycles after RESET falls; drop_pulse removes it for one cycle.
  initial begin
    pll_lock = 1'b0;
    forever begin
      @(posedge sys_clk);
      #2;
      if (pll_reset || !lock_en) begin
        lk_cnt   = 0;
        pll_lock = 1'b0;
      end else if (drop_pulse) begin
        pll_lock   = 1'b0;
        drop_pulse = 1'b0;
        drop_cyc   = cyc;
      end else if (lk_cnt >= LOCK_DLY) begin
        if (!pll_lock) begin
          pll_lock      = 1'b1;
          lock_rise_cyc = cyc;
        end
      end else begin
        lk_cnt++;
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [17:0] e;
    forever begin
      @(negedge sys_clk);
      if (sys_rst_n) begin
        if (cfg_done) begin
          if (done_exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_cfg_done: got 1 expected 0 (t=%0t)", $time);
          end else begin
            e = done_exp_q.pop_front();
            check("done_codes", codes(), e);
            check("done_clk_ok", clk_ok, 1);
          end
        end
        if (cfg_ack) begin
          if (ack_exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_cfg_ack: got 1 expected 0 (t=%0t)", $time);
          end else begin
            e = ack_exp_q.pop_front();
            @(negedge sys_clk);
            check("ack_codes_applied", codes(), e);
            check("ack_next_pll_reset", pll_reset, 1);
            check("ack_next_clk_ok", clk_ok, 0);
            check("ack_next_cfg_err", cfg_err, 0);
            check("ack_next_cfg_ack", cfg_ack, 0);
          end
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int n;
    sys_rst_n  = 1'b0;
    cfg_req    = 1'b0;
    cfg_idsel  = '0;
    cfg_fbdsel = '0;
    cfg_odsel  = '0;
    lock_en    = 1'b1;
    drop_pulse = 1'b0;

    // 1: boot
    @(negedge sys_clk);
    check_reset_values("rst");
    done_exp_q.push_back(DEF_CODES);
    @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    count_reset_high(n);
    check("boot_reset_len", n, RST_CYCLES);
    check("boot_codes", codes(), DEF_CODES);
    wait_sig(0, 1'b1, "boot_clk_ok");
    check("boot_lock_to_clk_ok", cyc - lock_rise_cyc, 2 + STABLE_CYCLES);
    check("boot_done_pulse", cfg_done, 1);
    @(negedge sys_clk);
    check("boot_done_width", cfg_done, 0);
    check("boot_clk_ok_hold", clk_ok, 1);

    // 2: reconfiguration while LOCKED
    ack_exp_q.push_back({6'd3, 6'd5, 6'd8});
    done_exp_q.push_back({6'd3, 6'd5, 6'd8});
    drive_req(6'd3, 6'd5, 6'd8);
    wait_sig(2, 1'b1, "t2_ack");
    check("t2_ack_in_locked", clk_ok, 1);
    release_req();
    count_reset_high(n);
    check("t2_reset_len", n, RST_CYCLES);
    wait_sig(0, 1'b1, "t2_relock");
    check("t2_lock_to_clk_ok", cyc - lock_rise_cyc, 2 + STABLE_CYCLES);

    // 3: lock never rises -> all attempts fail
    ack_exp_q.push_back({6'd7, 6'd9, 6'd2});
    @(posedge sys_clk);
    #1;
    lock_en    = 1'b0;
    cfg_req    = 1'b1;
    cfg_idsel  = 6'd7;
    cfg_fbdsel = 6'd9;
    cfg_odsel  = 6'd2;
    wait_sig(2, 1'b1, "t3_ack");
    release_req();
    n = 0;
    while (n < 300) begin
      @(negedge sys_clk);
      if (cfg_err === 1'b1) break;
      n++;
    end
    check("t3_fail_time", n, (1 + MAX_RETRY) * (RST_CYCLES + LOCK_TIMEOUT));
    check("t3_err", cfg_err, 1);
    check("t3_pll_reset", pll_reset, 1);
    check("t3_busy", busy, 0);
    check("t3_clk_ok", clk_ok, 0);
    check("t3_codes_kept", codes(), {6'd7, 6'd9, 6'd2});
    repeat (5) @(negedge sys_clk);
    check("t3_err_sticky", cfg_err, 1);
    lock_en = 1'b1;
    ack_exp_q.push_back({6'd10, 6'd11, 6'd12});
    done_exp_q.push_back({6'd10, 6'd11, 6'd12});
    drive_req(6'd10, 6'd11, 6'd12);
    wait_sig(2, 1'b1, "t3_recover_ack");
    check("t3_ack_while_failed", cfg_err, 1);
    release_req();
    wait_sig(0, 1'b1, "t3_relock");
    check("t3_lock_to_clk_ok", cyc - lock_rise_cyc, 2 + STABLE_CYCLES);

    // 4: one-cycle lock loss while LOCKED -> auto-relock with same codes
    done_exp_q.push_back({6'd10, 6'd11, 6'd12});
    @(posedge sys_clk);
    #1;
    drop_pulse = 1'b1;
    wait_sig(0, 1'b0, "t4_clk_ok_fall");
    check("t4_fall_delay", cyc - drop_cyc, 3);
    check("t4_busy", busy, 1);
    check("t4_pll_reset", pll_reset, 1);
    check("t4_codes_kept", codes(), {6'd10, 6'd11, 6'd12});

    // 5: request during WAIT_LOCK is held off until the first LOCKED cycle
    wait_sig(1, 1'b0, "t5_wait_lock");
    ack_exp_q.push_back({6'd20, 6'd21, 6'd22});
    drive_req(6'd20, 6'd21, 6'd22);
    wait_sig(2, 1'b1, "t5_ack");
    check("t5_ack_clk_ok", clk_ok, 1);
    check("t5_ack_first_locked", cfg_done, 1);
    check("t5_lock_to_ack", cyc - lock_rise_cyc, 2 + STABLE_CYCLES);
    release_req();

    // 6: asynchronous reset in the middle of STABLE
    wait_sig(1, 1'b0, "t6_wait_lock");
    repeat (15) @(negedge sys_clk);
    check("t6_pre_busy", busy, 1);
    check("t6_pre_clk_ok", clk_ok, 0);
    check("t6_pre_pll_reset", pll_reset, 0);
    check("t6_pre_codes", codes(), {6'd20, 6'd21, 6'd22});
    #2;
    sys_rst_n = 1'b0;
    #1;
    check_reset_values("t6_rst");
    done_exp_q.push_back(DEF_CODES);
    @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    wait_sig(0, 1'b1, "t6_reboot");
    check("t6_lock_to_clk_ok", cyc - lock_rise_cyc, 2 + STABLE_CYCLES);

    repeat (2) @(negedge sys_clk);
    check("done_queue_empty", done_exp_q.size(), 0);
    check("ack_queue_empty", ack_exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
